// File: rtl/mycpu_id_stage.sv
// Instruction-decode stage: holds one fetched instruction and requests a fetch redirect for taken BEQ/BNE/J.
// Optional feature: define MYCPU_ID_JR_EN to also redirect on JR (target = rs value).
module mycpu_id_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fs_to_ds_valid,
    input  logic [31:0] fs_pc,
    input  logic [31:0] inst_sram_rdata,
    output logic        ds_allowin,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic        es_allowin,
    output logic        ds_to_es_valid,
    output logic [31:0] ds_pc,
    output logic [31:0] ds_inst,
    output logic        jen,
    output logic [31:0] offset,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HOLD  = 2'd1,
        S_REDIR = 2'd2
    } state_t;

    state_t state;

    // Handshake: an instruction moves from fetch when fs_to_ds_valid && ds_allowin,
    // and leaves toward execute when ds_to_es_valid && es_allowin.
    logic capture;
    logic leave;

    assign ds_allowin     = (state == S_EMPTY) || es_allowin;
    assign ds_to_es_valid = (state != S_EMPTY);
    assign capture        = fs_to_ds_valid && ds_allowin;
    assign leave          = ds_to_es_valid && es_allowin;
    assign state_dbg      = state;

    assign rf_raddr1 = ds_inst[25:21];
    assign rf_raddr2 = ds_inst[20:16];

    logic [5:0]  op;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic        is_beq;
    logic        is_bne;
    logic        is_j;
    logic        taken;
    logic [31:0] target;

    assign op        = ds_inst[31:26];
    assign pc_plus4  = ds_pc + 32'd4;
    assign br_target = pc_plus4 + {{14{ds_inst[15]}}, ds_inst[15:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], ds_inst[25:0], 2'b00};
    assign is_beq    = (op == 6'b000100);
    assign is_bne    = (op == 6'b000101);
    assign is_j      = (op == 6'b000010);

`ifdef MYCPU_ID_JR_EN
    logic is_jr;
    assign is_jr = (op == 6'b000000) && (ds_inst[5:0] == 6'b001000);

    always_comb begin
        taken  = 1'b0;
        target = br_target;
        if (is_beq) begin
            taken = (rf_rdata1 == rf_rdata2);
        end else if (is_bne) begin
            taken = (rf_rdata1 != rf_rdata2);
        end else if (is_j) begin
            taken  = 1'b1;
            target = j_target;
        end else if (is_jr) begin
            taken  = 1'b1;
            target = rf_rdata1;
        end
    end
`else
    always_comb begin
        taken  = 1'b0;
        target = br_target;
        if (is_beq) begin
            taken = (rf_rdata1 == rf_rdata2);
        end else if (is_bne) begin
            taken = (rf_rdata1 != rf_rdata2);
        end else if (is_j) begin
            taken  = 1'b1;
            target = j_target;
        end
    end
`endif

    // Offset is relative to the fetch unit's current PC, not the branch's own PC.
    assign jen    = (state == S_HOLD) && taken;
    assign offset = jen ? (target - fs_pc) : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_EMPTY;
            ds_pc   <= RESET_PC;
            ds_inst <= 32'd0;
        end else if (capture) begin
            state   <= S_HOLD;
            ds_pc   <= fs_pc;
            ds_inst <= inst_sram_rdata;
        end else if (leave) begin
            state <= S_EMPTY;
        end else if (jen) begin
            state <= S_REDIR;
        end
    end

endmodule

// File: tb/tb_mycpu_id_stage.sv
// Bench for mycpu_id_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_mycpu_id_stage;

    localparam logic [31:0] RESET_PC = 32'hbfc00000;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        fs_to_ds_valid = 1'b0;
    logic [31:0] fs_pc = 32'd0;
    logic [31:0] inst_sram_rdata = 32'd0;
    logic [31:0] rf_rdata1 = 32'd0;
    logic [31:0] rf_rdata2 = 32'd0;
    logic        es_allowin = 1'b0;
    logic        ds_allowin;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic        ds_to_es_valid;
    logic [31:0] ds_pc;
    logic [31:0] ds_inst;
    logic        jen;
    logic [31:0] offset;
    logic [1:0]  state_dbg;

    mycpu_id_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_pc(fs_pc), .inst_sram_rdata(inst_sram_rdata),
        .ds_allowin(ds_allowin), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .es_allowin(es_allowin),
        .ds_to_es_valid(ds_to_es_valid), .ds_pc(ds_pc), .ds_inst(ds_inst),
        .jen(jen), .offset(offset), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    // The model remembers whether an instruction is held and whether its redirect already fired.
    bit          m_valid = 1'b0;
    bit          m_fired = 1'b0;
    logic [31:0] m_pc    = RESET_PC;
    logic [31:0] m_inst  = 32'd0;

    function automatic void ref_branch(input logic [31:0] pc, input logic [31:0] inst,
                                       input logic [31:0] r1, input logic [31:0] r2,
                                       output bit taken, output logic [31:0] target);
        int unsigned opc   = inst >> 26;
        int unsigned funct = inst & 32'h3f;
        int          simm  = $signed(inst[15:0]);
        logic [31:0] nxt   = pc + 32'd4;
        taken  = 1'b0;
        target = 32'd0;
        if (opc == 4 || opc == 5) begin
            taken  = (opc == 4) ? (r1 == r2) : (r1 != r2);
            target = nxt + 32'(simm * 4);
        end else if (opc == 2) begin
            taken  = 1'b1;
            target = (nxt & 32'hf000_0000) + (inst & 32'h03ff_ffff) * 4;
        end
`ifdef MYCPU_ID_JR_EN
        else if (opc == 0 && funct == 8) begin
            taken  = 1'b1;
            target = r1;
        end
`endif
    endfunction

    logic        e_allowin;
    logic        e_jen;
    logic [31:0] e_offset;

    function automatic void model_comb();
        bit          t;
        logic [31:0] tgt;
        ref_branch(m_pc, m_inst, rf_rdata1, rf_rdata2, t, tgt);
        e_allowin = !m_valid || es_allowin;
        e_jen     = m_valid && !m_fired && t;
        e_offset  = e_jen ? tgt - fs_pc : 32'd0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_inputs(input bit r, input bit fv, input logic [31:0] fpc,
                              input logic [31:0] inst, input logic [31:0] r1,
                              input logic [31:0] r2, input bit esa);
        @(negedge clk);
        rst = r; fs_to_ds_valid = fv; fs_pc = fpc; inst_sram_rdata = inst;
        rf_rdata1 = r1; rf_rdata2 = r2; es_allowin = esa;
        #1;
    endtask

    task automatic check_all();
        logic [31:0] inst_v;
        logic [1:0]  st;
        model_comb();
        inst_v = m_inst;
        st = !m_valid ? 2'd0 : (m_fired ? 2'd2 : 2'd1);
        check("ds_allowin", 32'(ds_allowin), 32'(e_allowin));
        check("ds_to_es_valid", 32'(ds_to_es_valid), 32'(m_valid));
        check("ds_pc", ds_pc, m_pc);
        check("ds_inst", ds_inst, m_inst);
        check("jen", 32'(jen), 32'(e_jen));
        check("offset", offset, e_offset);
        check("rf_raddr1", 32'(rf_raddr1), 32'(inst_v[25:21]));
        check("rf_raddr2", 32'(rf_raddr2), 32'(inst_v[20:16]));
        check("state", 32'(state_dbg), 32'(st));
    endtask

    task automatic tick();
        model_comb();
        @(posedge clk);
        if (!rst) begin
            m_valid = 0; m_fired = 0; m_pc = RESET_PC; m_inst = 0;
        end else if (fs_to_ds_valid && e_allowin) begin
            m_valid = 1; m_fired = 0; m_pc = fs_pc; m_inst = inst_sram_rdata;
        end else if (m_valid && es_allowin) begin
            m_valid = 0; m_fired = 0;
        end else if (e_jen) begin
            m_fired = 1;
        end
    endtask

    task automatic step(input bit r, input bit fv, input logic [31:0] fpc,
                        input logic [31:0] inst, input logic [31:0] r1,
                        input logic [31:0] r2, input bit esa);
        set_inputs(r, fv, fpc, inst, r1, r2, esa);
        check_all();
        tick();
    endtask

    function automatic logic [31:0] rand_inst(input logic [31:0] r1v);
        logic [31:0] w = $urandom;
        case ($urandom_range(0, 4))
            0: w = {6'b000100, w[25:0]};
            1: w = {6'b000101, w[25:0]};
            2: w = {6'b000010, w[25:0]};
            3: w = {6'b000000, w[25:21], 15'd0, 6'b001000};
            default: ;
        endcase
        return w;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int jen_count;
        logic [31:0] b2b[4];

        // reset held for two cycles
        step(0, 0, 0, 32'h12345678, 0, 0, 0);
        step(0, 1, 32'h1000, 32'h87654321, 0, 0, 1);
        set_inputs(1, 0, 32'hbfc00000, 32'hffffffff, 0, 0, 0);
        check_all();
        check("rst_valid", 32'(ds_to_es_valid), 0);
        check("rst_jen", 32'(jen), 0);
        check("rst_pc", ds_pc, 32'hbfc00000);
        check("rst_allowin", 32'(ds_allowin), 1);
        check("rst_offset", offset, 0);
        tick();

        // BEQ forward taken
        step(1, 1, 32'hbfc00010, {6'b000100, 5'd1, 5'd2, 16'h0004}, 0, 0, 1);
        set_inputs(1, 0, 32'hbfc00014, 0, 5, 5, 0);
        check_all();
        check("beq_jen", 32'(jen), 1);
        check("beq_offset", offset, 32'h00000010);
        tick();
        step(1, 0, 32'hbfc00014, 0, 5, 5, 1);

        // BNE backward taken
        step(1, 1, 32'hbfc00100, {6'b000101, 5'd3, 5'd4, 16'hfffe}, 0, 0, 1);
        set_inputs(1, 0, 32'hbfc00104, 0, 1, 2, 0);
        check_all();
        check("bne_jen", 32'(jen), 1);
        check("bne_offset", offset, 32'hfffffff8);
        tick();
        step(1, 0, 32'hbfc00104, 0, 1, 2, 1);

        // J held through a 5-cycle stall: exactly one redirect pulse
        step(1, 1, 32'hbfc00040, {6'b000010, 26'h0000123}, 0, 0, 1);
        jen_count = 0;
        for (int i = 0; i < 5; i++) begin
            set_inputs(1, 1, 32'hbfc00044, 32'hdeadbeef, 0, 0, 0);
            check_all();
            check("stall_valid", 32'(ds_to_es_valid), 1);
            if (jen) jen_count++;
            tick();
        end
        check("stall_jen_count", 32'(jen_count), 1);
        check("stall_state", 32'(state_dbg), 32'd2);
        check("stall_inst", ds_inst, {6'b000010, 26'h0000123});

        // reset with a pending redirect discards the instruction
        step(1, 1, 32'hbfc00080, {6'b000010, 26'h0000200}, 0, 0, 1);
        step(0, 0, 32'hbfc00084, 0, 0, 0, 0);
        set_inputs(1, 0, 32'hbfc00084, 0, 0, 0, 0);
        check_all();
        check("midrst_valid", 32'(ds_to_es_valid), 0);
        check("midrst_jen", 32'(jen), 0);
        tick();

        // back-to-back capture, no bubbles
        for (int i = 0; i < 4; i++) b2b[i] = {6'b000000, 5'(i), 5'(i + 1), 5'(i + 2), 11'h021};
        for (int i = 0; i < 4; i++) begin
            set_inputs(1, 1, 32'hbfc00300 + 32'(i * 4), b2b[i], 0, 0, 1);
            check_all();
            exp_q.push_back(b2b[i]);
            tick();
            #1;
            check("b2b_valid", 32'(ds_to_es_valid), 1);
            check("b2b_inst", ds_inst, exp_q.pop_front());
        end
        step(1, 0, 0, 0, 0, 0, 1);

        // JR
        step(1, 1, 32'hbfc00018, 32'h03e00008, 0, 0, 1);
        set_inputs(1, 0, 32'hbfc00020, 0, 32'hbfc00200, 0, 0);
        check_all();
`ifdef MYCPU_ID_JR_EN
        check("jr_jen", 32'(jen), 1);
        check("jr_offset", offset, 32'h000001e0);
`else
        check("jr_jen", 32'(jen), 0);
        check("jr_offset", offset, 0);
`endif
        tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r1v = $urandom;
            logic [31:0] r2v = ($urandom_range(0, 1) == 1) ? r1v : $urandom;
            step($urandom_range(0, 99) != 0, $urandom_range(0, 2) != 0, $urandom,
                 rand_inst(r1v), r1v, r2v, $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
